// File: rtl/ps2_scancode_receiver.sv
// PS/2 Set 2 device-to-host receiver: synchronise, glitch-filter, deserialise, strip E0/F0 prefixes.
// Optional build macro PS2_BREAK_SUPPRESS_EN: release bytes are consumed without a scan_valid pulse.
module ps2_scancode_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       break_flag,
    output logic       ext_flag,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;
    typedef enum logic [1:0] {ResNone, ResOk, ResParity, ResFrame} res_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout;
    res_t          res_q, res_d;
    logic [7:0]    res_byte_q, res_byte_d;

    logic          ext_lat_q, ext_lat_d;
    logic          brk_lat_q, brk_lat_d;
    logic [7:0]    scan_code_d;
    logic          scan_valid_d, break_flag_d, ext_flag_d, parity_err_d, frame_err_d;

    // Lines idle high, so synchronisers and filter reset high to avoid a false fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    assign fall = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign timeout = (state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        parity_d   = parity_q;
        res_d      = ResNone;
        res_byte_d = shift_q;

        if (fall || state_q == StIdle) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout) begin
            state_d = StIdle;
            res_d   = ResFrame;
            tmo_d   = '0;
        end else if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!data_s) begin
                        res_d = ResFrame;
                    end else if (^{shift_q, parity_q}) begin
                        res_d = ResOk;
                    end else begin
                        res_d = ResParity;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            res_q      <= ResNone;
            res_byte_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            res_q      <= res_d;
            res_byte_q <= res_byte_d;
        end
    end

    // Frame result is acted on one cycle after the stop-bit fall; errors never touch the latches.
    always_comb begin
        ext_lat_d    = ext_lat_q;
        brk_lat_d    = brk_lat_q;
        scan_code_d  = scan_code;
        break_flag_d = break_flag;
        ext_flag_d   = ext_flag;
        scan_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (res_q)
            ResOk: begin
                if (res_byte_q == 8'hE0) begin
                    ext_lat_d = 1'b1;
                end else if (res_byte_q == 8'hF0) begin
                    brk_lat_d = 1'b1;
                end else begin
                    ext_lat_d = 1'b0;
                    brk_lat_d = 1'b0;
`ifdef PS2_BREAK_SUPPRESS_EN
                    if (!brk_lat_q) begin
                        scan_code_d  = res_byte_q;
                        break_flag_d = 1'b0;
                        ext_flag_d   = ext_lat_q;
                        scan_valid_d = 1'b1;
                    end
`else
                    scan_code_d  = res_byte_q;
                    break_flag_d = brk_lat_q;
                    ext_flag_d   = ext_lat_q;
                    scan_valid_d = 1'b1;
`endif
                end
            end
            ResParity: parity_err_d = 1'b1;
            ResFrame:  frame_err_d  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_lat_q  <= 1'b0;
            brk_lat_q  <= 1'b0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ext_lat_q  <= ext_lat_d;
            brk_lat_q  <= brk_lat_d;
            scan_code  <= scan_code_d;
            scan_valid <= scan_valid_d;
            break_flag <= break_flag_d;
            ext_flag   <= ext_flag_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frame table plus timeout, glitch and reset sequences.
module tb_ps2_scancode_receiver;

    localparam int HALF = 20;
    localparam int LATENCY = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, break_flag, ext_flag, parity_err, frame_err;

    ps2_scancode_receiver #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(50000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .break_flag(break_flag),
        .ext_flag  (ext_flag),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
    int last_valid_cyc = 0;
    int stop_fall_cyc = 0;
    int n_checks = 0, n_pass = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (scan_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (parity_err) n_perr++;
        if (frame_err) n_ferr++;
        if (int'(scan_valid) + int'(parity_err) + int'(frame_err) > 1) n_overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        @(posedge clk); #1 ps2_data = v;
        if (glitch) begin
            repeat (6) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (HALF - 10) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_bit);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        int         exp_valid;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int v0, p0, f0;

        vecs[0]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0, 0};
        vecs[1]  = '{8'hF0, 0, 1, 0, 8'h1C, 0, 0, 0, 0};
`ifdef PS2_BREAK_SUPPRESS_EN
        vecs[2]  = '{8'h1C, 0, 1, 0, 8'h1C, 0, 0, 0, 0};
        vecs[3]  = '{8'hE0, 0, 1, 0, 8'h1C, 0, 0, 0, 0};
`else
        vecs[2]  = '{8'h1C, 0, 1, 1, 8'h1C, 1, 0, 0, 0};
        vecs[3]  = '{8'hE0, 0, 1, 0, 8'h1C, 1, 0, 0, 0};
`endif
        vecs[4]  = '{8'h5A, 0, 1, 1, 8'h5A, 0, 1, 0, 0};
        vecs[5]  = '{8'h16, 0, 1, 1, 8'h16, 0, 0, 0, 0};
        vecs[6]  = '{8'h16, 1, 1, 0, 8'h16, 0, 0, 1, 0};
        vecs[7]  = '{8'h45, 0, 1, 1, 8'h45, 0, 0, 0, 0};
        vecs[8]  = '{8'h33, 0, 0, 0, 8'h45, 0, 0, 0, 1};
        vecs[9]  = '{8'hF0, 0, 1, 0, 8'h45, 0, 0, 0, 0};
        vecs[10] = '{8'h22, 1, 1, 0, 8'h45, 0, 0, 1, 0};
`ifdef PS2_BREAK_SUPPRESS_EN
        vecs[11] = '{8'h1C, 0, 1, 0, 8'h45, 0, 0, 0, 0};
        vecs[12] = '{8'h29, 1, 0, 0, 8'h45, 0, 0, 0, 1};
`else
        vecs[11] = '{8'h1C, 0, 1, 1, 8'h1C, 1, 0, 0, 0};
        vecs[12] = '{8'h29, 1, 0, 0, 8'h1C, 1, 0, 0, 1};
`endif

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_scan_code", scan_code, 0);
        check("rst_scan_valid", scan_valid, 0);
        check("rst_break_flag", break_flag, 0);
        check("rst_ext_flag", ext_flag, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);

        for (int i = 0; i < 13; i++) begin
            v0 = n_valid; p0 = n_perr; f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop, 11, -1);
            check($sformatf("v%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("v%0d_code", i), scan_code, vecs[i].exp_code);
            check($sformatf("v%0d_brk", i), break_flag, vecs[i].exp_brk);
            check($sformatf("v%0d_ext", i), ext_flag, vecs[i].exp_ext);
            check($sformatf("v%0d_perr", i), n_perr - p0, vecs[i].exp_perr);
            check($sformatf("v%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_valid == 1)
                check($sformatf("v%0d_latency", i), last_valid_cyc - stop_fall_cyc, LATENCY);
        end

        // Short low glitches in idle (data low) and mid-frame must not be taken as falls.
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        @(posedge clk); #1 ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        send_frame(8'h4B, 0, 1, 11, 3);
        check("glitch_valid", n_valid - v0, 1);
        check("glitch_code", scan_code, 8'h4B);
        check("glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);

        // Frame abandoned after four data bits.
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h0F, 0, 1, 5, -1);
        check("tmo_early_ferr", n_ferr - f0, 0);
        repeat (50100) @(posedge clk);
        #1;
        check("tmo_ferr", n_ferr - f0, 1);
        check("tmo_valid", n_valid - v0, 0);
        check("tmo_perr", n_perr - p0, 0);
        send_frame(8'h26, 0, 1, 11, -1);
        check("tmo_next_valid", n_valid - v0, 1);
        check("tmo_next_code", scan_code, 8'h26);

        // Reset in the middle of the data bits.
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hA5, 0, 1, 5, -1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_code", scan_code, 0);
        check("midrst_ext", ext_flag, 0);
        rst = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        send_frame(8'h3D, 0, 1, 11, -1);
        check("midrst_errs", (n_perr - p0) + (n_ferr - f0), 0);
        check("midrst_valid", n_valid - v0, 1);
        check("midrst_code_3d", scan_code, 8'h3D);
        check("midrst_brk", break_flag, 0);

        check("pulse_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
